// File: rtl/m_execute_unit_if.sv
// Request/response bundle between the M-extension decoder and the execute unit.
// master: decoder side (drives start/op/operands/kill); slave: execute unit.
interface m_execute_unit_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  start;
  logic [5:0]            ALU_operation;
  logic [DATA_WIDTH-1:0] operand_A;
  logic [DATA_WIDTH-1:0] operand_B;
  logic                  kill;
  logic                  ready;
  logic                  valid;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, ALU_operation, operand_A, operand_B, kill,
    input  ready, valid, result
  );

  modport slave (
    input  start, ALU_operation, operand_A, operand_B, kill,
    output ready, valid, result
  );
endinterface

// File: rtl/m_execute_unit.sv
// Iterative RV64M/RV32M multiply/divide unit, one bit per cycle, fixed latency.
// Ports: clock, reset (async, active-high), bus (slave: start, ALU_operation,
// operand_A, operand_B, kill in; ready, valid, result out).
module m_execute_unit #(
  parameter int DATA_WIDTH = 64
) (
  input logic             clock,
  input logic             reset,
  m_execute_unit_if.slave bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIXUP, DONE} state_t;

  typedef enum logic [5:0] {
    OP_MUL   = 6'd20, OP_MULH  = 6'd21, OP_MULHU = 6'd22, OP_MULHSU = 6'd23,
    OP_DIV   = 6'd24, OP_DIVU  = 6'd25, OP_REM   = 6'd26, OP_REMU   = 6'd27,
    OP_MULW  = 6'd28, OP_DIVW  = 6'd29, OP_DIVUW = 6'd30, OP_REMW   = 6'd31,
    OP_REMUW = 6'd32
  } op_t;

  state_t         state, state_nxt;
  op_t            op_q;
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] mcand, prod;
  logic [W-1:0]   mplier, dvs, quo, rem;
  logic [6:0]     cnt;
  logic           neg_main, neg_rem, div_zero;
  logic [W-1:0]   result_q;

  logic           legal, accept;
  logic           w_op, a_sgn_op, b_sgn_op;
  logic [W-1:0]   a_ext, b_ext, a_mag, b_mag;
  logic           a_neg, b_neg;
  logic [W:0]     sh;
  logic           ge;
  logic [W-1:0]   diff;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s, rem_s, fix_val;

  function automatic logic [W-1:0] sx32(input logic [31:0] v);
    return W'(signed'(v));
  endfunction

  always_comb begin
    legal = (bus.ALU_operation >= 6'd20 && bus.ALU_operation <= 6'd27) ||
            (W == 64 && bus.ALU_operation >= 6'd28 && bus.ALU_operation <= 6'd32);
    accept = bus.start && legal && !bus.kill;
  end

  // Operand conditioning for PREP: extend W-op operands, then take magnitudes.
  always_comb begin
    w_op     = op_q inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    a_sgn_op = op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    b_sgn_op = op_q inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    a_ext    = a_q;
    b_ext    = b_q;
    if (w_op) begin
      a_ext = a_sgn_op ? sx32(a_q[31:0]) : W'(a_q[31:0]);
      b_ext = b_sgn_op ? sx32(b_q[31:0]) : W'(b_q[31:0]);
    end
    a_neg = a_sgn_op && a_ext[W-1];
    b_neg = b_sgn_op && b_ext[W-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end

  // Restoring divide step; diff only needs W bits because it is used only when sh >= dvs.
  always_comb begin
    sh   = {rem, quo[W-1]};
    ge   = sh >= {1'b0, dvs};
    diff = sh[W-1:0] - dvs;
  end

  always_comb begin
    prod_s  = neg_main ? -prod : prod;
    quo_s   = div_zero ? '1 : (neg_main ? -quo : quo);
    rem_s   = neg_rem ? -rem : rem;
    fix_val = '0;
    case (op_q)
      OP_MUL:                       fix_val = prod_s[W-1:0];
      OP_MULH, OP_MULHU, OP_MULHSU: fix_val = prod_s[2*W-1:W];
      OP_MULW:                      fix_val = sx32(prod_s[31:0]);
      OP_DIV, OP_DIVU:              fix_val = quo_s;
      OP_REM, OP_REMU:              fix_val = rem_s;
      OP_DIVW, OP_DIVUW:            fix_val = sx32(quo_s[31:0]);
      OP_REMW, OP_REMUW:            fix_val = sx32(rem_s[31:0]);
      default:                      fix_val = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = PREP;
      PREP:  state_nxt = bus.kill ? IDLE : CALC;
      CALC:  if (bus.kill) state_nxt = IDLE;
             else if (cnt == 7'd1) state_nxt = FIXUP;
      FIXUP: state_nxt = bus.kill ? IDLE : DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready  = (state == IDLE);
    bus.valid  = (state == DONE);
    bus.result = result_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      mcand    <= '0;
      prod     <= '0;
      mplier   <= '0;
      dvs      <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= op_t'(bus.ALU_operation);
            a_q  <= bus.operand_A;
            b_q  <= bus.operand_B;
          end
        end
        PREP: begin
          mcand    <= (2*W)'(a_mag);
          mplier   <= b_mag;
          prod     <= '0;
          dvs      <= b_mag;
          // W-op dividends are pre-aligned to the top so 32 steps consume them fully.
          quo      <= w_op ? (a_mag << 32) : a_mag;
          rem      <= '0;
          cnt      <= w_op ? 7'd32 : 7'(W);
          neg_main <= a_neg ^ b_neg;
          neg_rem  <= a_neg;
          div_zero <= (b_ext == '0);
        end
        CALC: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          rem    <= ge ? diff : sh[W-1:0];
          quo    <= {quo[W-2:0], ge};
          cnt    <= cnt - 7'd1;
        end
        FIXUP: begin
          if (!bus.kill) result_q <= fix_val;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_m_execute_unit.sv
module tb_m_execute_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int unsigned checks = 0;
  int unsigned passed = 0;
  logic [63:0] exp_q[$];

  m_execute_unit_if #(.DATA_WIDTH(64)) bus ();

  m_execute_unit #(.DATA_WIDTH(64)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every valid pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    logic [63:0] e;
    if (bus.valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_valid: got valid=1 result=%h, required no valid", bus.result);
      end else begin
        e = exp_q.pop_front();
        if (bus.result !== e)
          $display("FAIL result: got %h, required %h", bus.result, e);
        else
          passed++;
      end
    end
  end

  function automatic logic [63:0] model(input logic [5:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [127:0] sa128, sb128, sp;
    logic [127:0]        up;
    logic signed [63:0]  as, bs;
    logic signed [31:0]  a32, b32;
    logic [31:0]         r32;
    as = a; bs = b; a32 = a[31:0]; b32 = b[31:0];
    r32 = '0; up = '0;
    sa128 = as; sb128 = bs;
    case (op)
      6'd20: begin up = {64'd0, a} * {64'd0, b}; return up[63:0]; end
      6'd21: begin sp = sa128 * sb128; return sp[127:64]; end
      6'd22: begin up = {64'd0, a} * {64'd0, b}; return up[127:64]; end
      6'd23: begin sb128 = {64'd0, b}; sp = sa128 * sb128; return sp[127:64]; end
      6'd24: begin
        if (b == 64'd0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        return as / bs;
      end
      6'd25: return (b == 64'd0) ? '1 : a / b;
      6'd26: begin
        if (b == 64'd0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
        return as % bs;
      end
      6'd27: return (b == 64'd0) ? a : a % b;
      6'd28: r32 = a[31:0] * b[31:0];
      6'd29: begin
        if (b32 == 0) r32 = '1;
        else if (a32 == 32'sh8000_0000 && b32 == -1) r32 = a32;
        else r32 = a32 / b32;
      end
      6'd30: r32 = (b[31:0] == 32'd0) ? '1 : a[31:0] / b[31:0];
      6'd31: begin
        if (b32 == 0) r32 = a32;
        else if (a32 == 32'sh8000_0000 && b32 == -1) r32 = '0;
        else r32 = a32 % b32;
      end
      6'd32: r32 = (b[31:0] == 32'd0) ? a[31:0] : a[31:0] % b[31:0];
      default: return '0;
    endcase
    return {{32{r32[31]}}, r32};
  endfunction

  // Drives one start cycle; returns 1 ns after the sampling edge E0.
  task automatic start_op(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
    bus.start = 1'b1;
    bus.ALU_operation = op;
    bus.operand_A = a;
    bus.operand_B = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after E0 until valid is seen, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.valid !== 1'b1 && lat < 300) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #3 reset = 1'b1;
    #1;
    checks++; if (bus.ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", bus.ready); else passed++;
    checks++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", bus.valid); else passed++;
    checks++; if (bus.result !== 64'd0) $display("FAIL reset_result: got %h, required 0", bus.result); else passed++;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_mul;
    int lat;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    start_op(6'd20, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    checks++; if (bus.ready !== 1'b0) $display("FAIL mul_busy: got ready=%b, required 0", bus.ready); else passed++;
    wait_valid(lat);
    checks++; if (lat != 66) $display("FAIL mul_latency: got %0d, required 66", lat); else passed++;
    @(posedge clock); #1;
    checks++; if (bus.ready !== 1'b1) $display("FAIL mul_ready_back: got %b, required 1", bus.ready); else passed++;
    checks++; if (bus.valid !== 1'b0) $display("FAIL mul_valid_pulse: got %b, required 0", bus.valid); else passed++;
  endtask

  task automatic run_table(input string name, input logic [5:0] ops[], input logic [63:0] as[],
                           input logic [63:0] bs[], input logic [63:0] ex[], input int exp_lat);
    int lat;
    foreach (ops[i]) begin
      exp_q.push_back(ex[i]);
      start_op(ops[i], as[i], bs[i]);
      wait_valid(lat);
      checks++;
      if (lat != exp_lat) $display("FAIL %s_latency[%0d]: got %0d, required %0d", name, i, lat, exp_lat);
      else passed++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_mulh;
    run_table("mulh", '{6'd21, 6'd22, 6'd23},
              '{64'h8000_0000_0000_0000, '1, '1},
              '{64'h8000_0000_0000_0000, '1, 64'd2},
              '{64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, '1}, 66);
  endtask

  task automatic test_div_corners;
    run_table("divc", '{6'd24, 6'd27, 6'd24, 6'd26},
              '{64'd20, 64'd20, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000},
              '{64'd0, 64'd0, '1, '1},
              '{'1, 64'd20, 64'h8000_0000_0000_0000, 64'd0}, 66);
  endtask

  task automatic test_wops;
    run_table("wop", '{6'd29, 6'd28, 6'd32},
              '{64'h1_8000_0000, 64'h7FFF_FFFF, 64'd7},
              '{'1, 64'd2, 64'd0},
              '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'd7}, 34);
  endtask

  task automatic test_random;
    int lat;
    logic [5:0] op;
    logic [63:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 6'($urandom_range(20, 32));
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 1000)) * (($urandom_range(0, 1) == 1) ? 64'd1 : '1);
        default: b = {$urandom, $urandom};
      endcase
      exp_q.push_back(model(op, a, b));
      start_op(op, a, b);
      wait_valid(lat);
      checks++;
      if (lat != ((op >= 6'd28) ? 34 : 66))
        $display("FAIL rand_latency[%0d]: op=%0d got %0d, required %0d", i, op, lat, (op >= 6'd28) ? 34 : 66);
      else passed++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    exp_q.push_back(64'd30);
    start_op(6'd20, 64'd5, 64'd6);
    repeat (5) @(posedge clock);
    #1;
    start_op(6'd24, 64'd100, 64'd7);
    wait_valid(lat);
    checks++; if (lat != 60) $display("FAIL busy_start_latency: got %0d, required 60", lat); else passed++;
    @(posedge clock); #1;
    // Genuine back-to-back request on the first ready cycle.
    exp_q.push_back(model(6'd25, 64'd100, 64'd7));
    start_op(6'd25, 64'd100, 64'd7);
    wait_valid(lat);
    checks++; if (lat != 66) $display("FAIL b2b_latency: got %0d, required 66", lat); else passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_illegal;
    int busy = 0;
    start_op(6'd6, 64'd1, 64'd1);
    checks++; if (bus.ready !== 1'b1) $display("FAIL illegal_ready: got %b, required 1", bus.ready); else passed++;
    repeat (70) begin
      @(posedge clock); #1;
      if (bus.ready !== 1'b1) busy++;
    end
    checks++; if (busy != 0) $display("FAIL illegal_busy_cycles: got %0d, required 0", busy); else passed++;
  endtask

  task automatic test_kill;
    int lat;
    int vcount = 0;
    exp_q.push_back(64'd12);
    start_op(6'd20, 64'd3, 64'd4);
    wait_valid(lat);
    @(posedge clock); #1;
    start_op(6'd24, 64'd1000, 64'd3);
    repeat (10) @(posedge clock);
    #1;
    bus.kill = 1'b1;
    @(posedge clock); #1;
    bus.kill = 1'b0;
    checks++; if (bus.ready !== 1'b1) $display("FAIL kill_ready: got %b, required 1", bus.ready); else passed++;
    checks++; if (bus.result !== 64'd12) $display("FAIL kill_result: got %h, required %h", bus.result, 64'd12); else passed++;
    repeat (80) begin
      @(posedge clock); #1;
      if (bus.valid === 1'b1) vcount++;
    end
    checks++; if (vcount != 0) $display("FAIL kill_valid_count: got %0d, required 0", vcount); else passed++;
  endtask

  task automatic test_async_reset;
    int lat;
    int vcount = 0;
    start_op(6'd22, '1, 64'd3);
    repeat (20) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.ready !== 1'b1) $display("FAIL areset_ready: got %b, required 1", bus.ready); else passed++;
    checks++; if (bus.valid !== 1'b0) $display("FAIL areset_valid: got %b, required 0", bus.valid); else passed++;
    checks++; if (bus.result !== 64'd0) $display("FAIL areset_result: got %h, required 0", bus.result); else passed++;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (80) begin
      @(posedge clock); #1;
      if (bus.valid === 1'b1) vcount++;
    end
    checks++; if (vcount != 0) $display("FAIL areset_valid_count: got %0d, required 0", vcount); else passed++;
    exp_q.push_back(64'd6);
    start_op(6'd20, 64'd2, 64'd3);
    wait_valid(lat);
    checks++; if (lat != 66) $display("FAIL post_reset_latency: got %0d, required 66", lat); else passed++;
    @(posedge clock); #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.kill = 1'b0;
    bus.ALU_operation = '0;
    bus.operand_A = '0;
    bus.operand_B = '0;
    test_reset();
    test_mul();
    test_mulh();
    test_div_corners();
    test_wops();
    test_random();
    test_back_to_back();
    test_illegal();
    test_kill();
    test_async_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) $display("FAIL pending_results: got %0d outstanding, required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
